queue_stream_reader: RTL and testbench

- Read-side consumer for the `queue` FIFO. It drives the queue's dequeue and absorbs the 1-cycle registered RAM read latency.
- Presents the queue contents as a valid/ready stream with a 2-entry output buffer, sustaining 1 word/cycle.
- Sits between any `queue` instance and a downstream stage, e.g. the labeling/blob pipeline consuming queued pixel or coordinate words.
- Also counts delivered words for frame bookkeeping.

---
 rtl/queue_stream_reader_if.sv | 22 ++
 rtl/queue_stream_reader.sv | 95 +++++++++
 tb/tb_queue_stream_reader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/queue_stream_reader_if.sv
// Queue read port plus valid/ready output stream, bundled for the queue reader.
// master is the reader; slave is the queue/downstream side.
interface queue_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  q_empty;
    logic [DATA_WIDTH-1:0] q_data;
    logic                  q_dequeue;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  q_empty, q_data, m_ready,
        output q_dequeue, m_valid, m_data
    );

    modport slave (
        output q_empty, q_data, m_ready,
        input  q_dequeue, m_valid, m_data
    );
endinterface

// File: rtl/queue_stream_reader.sv
// Drains a queue with 1-cycle registered read latency into a valid/ready stream
// through a 2-entry buffer, and counts delivered words.
module queue_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    queue_stream_reader_if.master bus,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] xfer_count,
    output logic                 busy
);
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [1:0]            level_after;

    // occ + inflight never exceeds 2, so a 2-bit level is enough
    always_comb begin
        pop         = (occ_q != 2'd0) && bus.m_ready;
        push        = inflight_q;
        level_after = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        issue       = reset_n && !bus.q_empty && (level_after < 2'd2);
    end

    always_comb begin
        buf_d = buf_q;
        occ_d = occ_q;
        case ({push, pop})
            2'b10: begin
                buf_d[occ_q[0]] = bus.q_data;
                occ_d           = occ_q + 2'd1;
            end
            2'b01: begin
                buf_d[0] = buf_q[1];
                occ_d    = occ_q - 2'd1;
            end
            2'b11: begin
                // head leaves as the captured word arrives; occupancy unchanged
                if (occ_q == 2'd1) begin
                    buf_d[0] = bus.q_data;
                end else begin
                    buf_d[0] = buf_q[1];
                    buf_d[1] = bus.q_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        inflight_d = issue;
        cnt_d      = cnt_q;
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (pop) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                buf_q[gi] <= '0;
            end else begin
                buf_q[gi] <= buf_d[gi];
            end
        end
    end

    assign bus.q_dequeue = issue;
    assign bus.m_valid   = (occ_q != 2'd0);
    assign bus.m_data    = buf_q[0];
    assign xfer_count    = cnt_q;
    assign busy          = (occ_q != 2'd0) || inflight_q;
endmodule

// File: tb/tb_queue_stream_reader.sv
// Directed bench for queue_stream_reader: a behavioural queue feeds the reader
// and each delivered word, flag and counter value is compared to hand-derived values.
module tb_queue_stream_reader;
    localparam int DW = 32;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cnt_clear = 1'b0;
    logic [CW-1:0] xfer_count;
    logic          busy;
    logic          enq_v = 1'b0;
    logic [DW-1:0] enq_d = '0;

    int n_checks = 0;
    int n_errors = 0;
    int deq_total = 0;
    int outstanding = 0;
    int max_out = 0;
    int underflow = 0;
    logic [DW-1:0] qm [$];

    queue_stream_reader_if #(.DATA_WIDTH(DW)) ifc ();

    queue_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (ifc),
        .cnt_clear  (cnt_clear),
        .xfer_count (xfer_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Queue model: data_out registered one cycle after a dequeue edge
    always @(posedge clk) begin
        if (!reset_n) begin
            qm.delete();
            ifc.q_data  <= '0;
            ifc.q_empty <= 1'b1;
            outstanding = 0;
        end else begin
            if (ifc.m_valid && ifc.m_ready)
                $display("xfer data=0x%08h count_before=%0d", ifc.m_data, xfer_count);
            if (ifc.q_dequeue) begin
                if (ifc.q_empty || qm.size() == 0) underflow++;
                else ifc.q_data <= qm.pop_front();
                deq_total++;
            end
            if (enq_v) qm.push_back(enq_d);
            ifc.q_empty <= (qm.size() == 0);
            outstanding = outstanding + (ifc.q_dequeue ? 1 : 0) - ((ifc.m_valid && ifc.m_ready) ? 1 : 0);
            if (outstanding > max_out) max_out = outstanding;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Enqueue n words base+i, one per cycle, and drain them all in order
    task automatic run_stream(input int n, input bit rnd, input logic [DW-1:0] base);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 20 * n + 100) begin
            @(negedge clk);
            if (sent < n) begin
                enq_v = 1'b1;
                enq_d = base + DW'(sent);
                sent++;
            end else begin
                enq_v = 1'b0;
            end
            ifc.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (ifc.m_valid && ifc.m_ready) begin
                check("stream_data", ifc.m_data, base + DW'(got));
                got++;
            end
            cyc++;
        end
        @(negedge clk);
        enq_v = 1'b0;
        ifc.m_ready = 1'b0;
        check("stream_done", got, n);
    endtask

    // One word through the reader, popped with optional simultaneous clear
    task automatic single_pop(input bit clr, input logic [DW-1:0] d);
        @(negedge clk);
        ifc.m_ready = 1'b0;
        enq_v = 1'b1;
        enq_d = d;
        @(negedge clk);
        enq_v = 1'b0;
        repeat (3) @(negedge clk);
        check("single_valid", ifc.m_valid, 1);
        check("single_data", ifc.m_data, d);
        ifc.m_ready = 1'b1;
        cnt_clear = clr;
        @(negedge clk);
        ifc.m_ready = 1'b0;
        cnt_clear = 1'b0;
        #1;
        check("single_drained", ifc.m_valid, 0);
    endtask

    initial begin
        int deq_base;
        ifc.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_deq", ifc.q_dequeue, 0);
            check("idle_valid", ifc.m_valid, 0);
            check("idle_busy", busy, 0);
            check("idle_cnt", xfer_count, 0);
        end

        // Three words, checking exact latency and back-to-back delivery
        ifc.m_ready = 1'b1;
        enq_v = 1'b1; enq_d = 32'h11;
        @(negedge clk);
        check("lat_deq_first", ifc.q_dequeue, 1);
        check("lat_valid_c0", ifc.m_valid, 0);
        enq_d = 32'h22;
        @(negedge clk);
        check("lat_valid_c1", ifc.m_valid, 0);
        check("lat_busy_c1", busy, 1);
        enq_d = 32'h33;
        @(negedge clk);
        enq_v = 1'b0;
        check("w0_valid", ifc.m_valid, 1);
        check("w0_data", ifc.m_data, 32'h11);
        @(negedge clk);
        check("w1_valid", ifc.m_valid, 1);
        check("w1_data", ifc.m_data, 32'h22);
        @(negedge clk);
        check("w2_valid", ifc.m_valid, 1);
        check("w2_data", ifc.m_data, 32'h33);
        @(negedge clk);
        check("three_done", ifc.m_valid, 0);
        check("three_cnt", xfer_count, 3);
        ifc.m_ready = 1'b0;

        // 256 words with random backpressure
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        #1;
        check("clear_only", xfer_count, 0);
        run_stream(256, 1'b1, 32'h0);
        check("rand_cnt", xfer_count, 256);
        check("no_underflow", underflow, 0);
        check("occ_le2", (max_out > 2), 0);

        // Stall with 5 words queued, then release
        deq_base = deq_total;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            enq_v = 1'b1;
            enq_d = DW'(i);
        end
        @(negedge clk);
        enq_v = 1'b0;
        repeat (5) @(negedge clk);
        check("bp_deq_count", deq_total - deq_base, 2);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", ifc.m_valid, 1);
            check("bp_data", ifc.m_data, 0);
            @(negedge clk);
        end
        ifc.m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_rel_valid", ifc.m_valid, 1);
            check("bp_rel_data", ifc.m_data, DW'(k));
            @(negedge clk);
        end
        ifc.m_ready = 1'b0;
        #1;
        check("bp_rel_done", ifc.m_valid, 0);
        check("bp_cnt", xfer_count, 261);

        // Reset mid-stream with a full buffer and words still queued
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            enq_v = 1'b1;
            enq_d = 32'hB0 + DW'(i);
        end
        @(negedge clk);
        enq_v = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_valid", ifc.m_valid, 1);
        reset_n = 1'b0;
        ifc.m_ready = 1'b1;
        #1;
        check("rst_deq_forced", ifc.q_dequeue, 0);
        @(negedge clk);
        reset_n = 1'b1;
        ifc.m_ready = 1'b0;
        #1;
        check("rst_valid", ifc.m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", xfer_count, 0);
        check("rst_data", ifc.m_data, 0);
        run_stream(2, 1'b0, 32'hC0);
        check("post_rst_cnt", xfer_count, 2);

        // Counter wrap, then clear colliding with a pop at all-ones
        run_stream(1021, 1'b0, 32'h1000);
        check("cnt_max", xfer_count, 10'h3FF);
        single_pop(1'b0, 32'hDEAD);
        check("cnt_wrap", xfer_count, 0);
        run_stream(1023, 1'b0, 32'h2000);
        check("cnt_max2", xfer_count, 10'h3FF);
        single_pop(1'b1, 32'hBEEF);
        check("cnt_clear_pop", xfer_count, 0);
        check("final_underflow", underflow, 0);
        check("final_occ_le2", (max_out > 2), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
